cb_heep_fault_inj_sched: RTL and testbench
==========================================

// Module: cb_heep_fault_inj_sched
// PURPOSE
//  Sequences soft-error injection into the cross-bar HEEP cores. Replaces the single static
//  force-error bit with a programmed campaign: initial delay, pulse width, recovery handshake,
//  inter-pulse gap, pulse count. Targets are selected round-robin over an enable mask.
//  Sits beside the control register block; config/start/abort come from its reg2hw fields.
// PARAMETERS
//  N_TGT      3     number of injection targets (cores); >=1
//  CNT_W      16    width of all config fields and counters
//  TO_CYCLES  1024  WAIT_ACK timeout in cycles (used only with CB_HEEP_INJ_TIMEOUT_EN); >=1
// PORTS
//  clk_i          in   1      clock
//  rst_i          in   1      synchronous reset, active-high
//  start_i        in   1      start campaign (level, sampled in IDLE only)
//  abort_i        in   1      abort campaign (any state)
//  cfg_delay_i    in   CNT_W  cycles from start to first pulse
//  cfg_width_i    in   CNT_W  pulse width in cycles (0 treated as 1)
//  cfg_gap_i      in   CNT_W  cycles between ack and next pulse
//  cfg_num_i      in   CNT_W  number of pulses in campaign
//  cfg_mask_i     in   N_TGT  target enable mask
//  recov_ack_i    in   1      system recovered from last injection
//  force_error_o  out  N_TGT  one-hot (or zero) injection strobe, registered
//  busy_o         out  1      campaign in progress (state != IDLE)
//  done_o         out  1      1-cycle pulse on normal or timeout completion
//  inj_cnt_o      out  CNT_W  pulses completed (acked) in current/last campaign
//  timeout_o      out  1      sticky: campaign ended by ack timeout
// BEHAVIOUR
//  - Reset: state IDLE; force_error_o=0, busy_o=0, done_o=0, inj_cnt_o=0, timeout_o=0, tgt ptr=0.
//  - All outputs registered. FSM: IDLE, DELAY, PULSE, WAIT_ACK, GAP.
//  - IDLE: on start_i && !abort_i, latch all cfg_* into shadow regs, clear inj_cnt_o and timeout_o.
//    If num==0 or mask==0: stay IDLE, done_o=1 next cycle, no pulse. Else -> DELAY.
//  - cfg_* changes after start have no effect until the next start.
//  - DELAY: lasts exactly D=cfg_delay cycles; D=0 goes straight to PULSE. Start sampled at edge t
//    => force_error_o high in cycles t+1+D .. t+D+W (W=max(cfg_width,1)).
//  - Target: first pulse uses lowest set mask bit; each subsequent pulse uses next set bit above
//    previous, wrapping to lowest. Exactly one force_error_o bit high during PULSE.
//  - PULSE -> WAIT_ACK after W cycles; force_error_o=0 from the first WAIT_ACK cycle.
//  - WAIT_ACK: recov_ack_i sampled only here (ack during PULSE/GAP ignored). On ack: inj_cnt_o++;
//    if inj_cnt_o+1==num -> IDLE with done_o=1 same edge; else -> GAP.
//  - GAP: lasts G=cfg_gap cycles (G=0 => next cycle is PULSE), then PULSE on next target.
//  - inj_cnt_o saturates impossible (bounded by num); no wrap.
//  - abort_i (any non-IDLE state): -> IDLE on next edge; force_error_o=0, busy_o=0 next cycle;
//    done_o NOT pulsed; inj_cnt_o and timeout_o retain values. abort_i with start_i in IDLE: abort wins.
//  - rst_i mid-campaign: immediate return to reset values on that edge.
//  - busy_o=1 exactly while state != IDLE; start_i ignored while busy.
// CONFIGURATION
//  CB_HEEP_INJ_TIMEOUT_EN defined: WAIT_ACK counts cycles; if TO_CYCLES elapse without ack,
//    timeout_o<=1 (sticky until next accepted start), done_o=1, -> IDLE; inj_cnt_o not incremented.
//  Not defined: WAIT_ACK waits indefinitely; timeout_o tied 0; no timeout counter synthesized.
// TESTING
//  1 delay=3,width=2,gap=1,num=2,mask=3'b101,ack 1 cyc after each pulse -> pulses on bit0 then bit2,
//    first pulse cycles t+4..t+5, done_o once, inj_cnt_o=2.
//  2 num=0 or mask=0, start -> no force_error_o, done_o pulse at t+1, busy_o never high.
//  3 width=0,delay=0,num=4,mask=3'b010 -> four 1-cycle pulses all on bit1, first at t+1.
//  4 abort mid-PULSE (num=3 after 1 ack) -> force_error_o=0 next cycle, no done_o, inj_cnt_o=1.
//  5 ack held high throughout -> ack ignored in PULSE; each WAIT_ACK lasts exactly 1 cycle.
//  6 [TIMEOUT_EN, TO_CYCLES=8] no ack -> timeout_o=1, done_o after 8 WAIT_ACK cycles, inj_cnt_o=0;
//    next start clears timeout_o. [Without macro] busy_o stays high until abort.

Source files
------------

// File: rtl/cb_heep_fault_inj_sched.sv
// Soft-error injection scheduler for the cross-bar HEEP cores.
// Runs a programmed campaign: initial delay, pulse, wait for recovery ack,
// gap, and repeat for a programmed number of pulses. Targets rotate
// round-robin over an enable mask.
// Optional feature: define CB_HEEP_INJ_TIMEOUT_EN to bound the recovery wait
// by TO_CYCLES cycles; otherwise the wait is unbounded and timeout_o is 0.
module cb_heep_fault_inj_sched #(
  parameter int unsigned N_TGT     = 3,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TO_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] cfg_delay_i,
  input  logic [CNT_W-1:0] cfg_width_i,
  input  logic [CNT_W-1:0] cfg_gap_i,
  input  logic [CNT_W-1:0] cfg_num_i,
  input  logic [N_TGT-1:0] cfg_mask_i,
  input  logic             recov_ack_i,
  output logic [N_TGT-1:0] force_error_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] inj_cnt_o,
  output logic             timeout_o
);

  localparam int unsigned TGT_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
  localparam int unsigned TO_W  = $clog2(TO_CYCLES + 1);

  // Elaboration-time parameter sanity
  if (N_TGT < 1 || TO_CYCLES < 1) begin : g_bad_param
    $error("cb_heep_fault_inj_sched: N_TGT and TO_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_PULSE,
    S_WAIT_ACK,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TGT_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [N_TGT-1:0] mask_q, mask_d;
  logic [N_TGT-1:0] force_q, force_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Next enabled target strictly above cur, wrapping; cur kept if mask is empty
  function automatic logic [TGT_W-1:0] next_tgt(input logic [N_TGT-1:0] mask,
                                                input logic [TGT_W-1:0] cur);
    logic [TGT_W-1:0] res;
    logic             found;
    int               idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= int'(N_TGT); k++) begin
      idx = (int'(cur) + k) % int'(N_TGT);
      if (!found && mask[TGT_W'(idx)]) begin
        res   = TGT_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Pulse width minus one, with a programmed width of 0 behaving as 1
  function automatic logic [CNT_W-1:0] width_m1(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  // Campaign sequencing: next state, counters and registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    width_d   = width_q;
    gap_d     = gap_q;
    num_d     = num_q;
    mask_d    = mask_q;
    inj_cnt_d = inj_cnt_q;
    done_d    = 1'b0;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          width_d   = cfg_width_i;
          gap_d     = cfg_gap_i;
          num_d     = cfg_num_i;
          mask_d    = cfg_mask_i;
          inj_cnt_d = '0;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          if (cfg_num_i == '0 || cfg_mask_i == '0) begin
            done_d = 1'b1;
          end else begin
            tgt_d = next_tgt(cfg_mask_i, TGT_W'(N_TGT - 1));
            if (cfg_delay_i == '0) begin
              state_d = S_PULSE;
              cnt_d   = width_m1(cfg_width_i);
            end else begin
              state_d = S_DELAY;
              cnt_d   = cfg_delay_i - CNT_W'(1);
            end
          end
        end
      end

      S_DELAY: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = width_m1(width_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_ACK;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WAIT_ACK: begin
        if (recov_ack_i) begin
          inj_cnt_d = inj_cnt_q + CNT_W'(1);
          if (inj_cnt_q + CNT_W'(1) == num_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            tgt_d = next_tgt(mask_q, tgt_q);
            if (gap_q == '0) begin
              state_d = S_PULSE;
              cnt_d   = width_m1(width_q);
            end else begin
              state_d = S_GAP;
              cnt_d   = gap_q - CNT_W'(1);
            end
          end
        end
`ifdef CB_HEEP_INJ_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = width_m1(width_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort drops the campaign silently, keeping the progress counters
    if (abort_i && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      done_d    = 1'b0;
      inj_cnt_d = inj_cnt_q;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
      timeout_d = timeout_q;
`endif
    end

    force_d = (state_d == S_PULSE) ? (N_TGT'(1) << tgt_d) : '0;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tgt_q     <= '0;
      width_q   <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      mask_q    <= '0;
      force_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      inj_cnt_q <= '0;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      width_q   <= width_d;
      gap_q     <= gap_d;
      num_q     <= num_d;
      mask_q    <= mask_d;
      force_q   <= force_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      inj_cnt_q <= inj_cnt_d;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign force_error_o = force_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign inj_cnt_o     = inj_cnt_q;
`ifdef CB_HEEP_INJ_TIMEOUT_EN
  assign timeout_o     = timeout_q;
`else
  assign timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cb_heep_fault_inj_sched.sv
// Self-checking bench for cb_heep_fault_inj_sched: table of campaigns plus
// hand-written abort, reset and recovery-timeout sequences.
module tb_cb_heep_fault_inj_sched;

  localparam int unsigned N_TGT = 3;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_delay, cfg_width, cfg_gap, cfg_num;
  logic [N_TGT-1:0] cfg_mask;
  logic             ack;
  logic [N_TGT-1:0] force_error;
  logic             busy, done, timeout;
  logic [CNT_W-1:0] inj_cnt;

  int tests = 0;
  int fails = 0;

  cb_heep_fault_inj_sched #(
    .N_TGT(N_TGT), .CNT_W(CNT_W), .TO_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .cfg_delay_i(cfg_delay), .cfg_width_i(cfg_width), .cfg_gap_i(cfg_gap),
    .cfg_num_i(cfg_num), .cfg_mask_i(cfg_mask), .recov_ack_i(ack),
    .force_error_o(force_error), .busy_o(busy), .done_o(done),
    .inj_cnt_o(inj_cnt), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] delay, width, gap, num;
    logic [2:0]  mask;
    bit          hold_ack;   // ack held high for the whole run
    int          first;      // cycle of first pulse (cycle 1 = right after start edge)
    int          second;     // cycle of second pulse start
    int          w;          // width of first pulse
    logic [2:0]  t0, t1, t2; // targets of first three pulses
    int          npulse;
    int          cnt;
    int          done_k;     // cycle in which done_o is seen
    bit          busy_seen;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input logic [15:0] d, w, g, n, input logic [2:0] m);
    cfg_delay = d; cfg_width = w; cfg_gap = g; cfg_num = n; cfg_mask = m;
  endtask

  // Run one campaign, acking one cycle after each pulse (or holding ack high)
  task automatic run_vec(input int id, input vec_t v);
    int         npulse, first, second, w1, done_n, done_k, post;
    logic [2:0] prev, fe;
    logic [2:0] t[3];
    bit         busy_seen, bad_hot, finished;
    npulse = 0; first = 0; second = 0; w1 = 0; done_n = 0; done_k = 0; post = 0;
    prev = '0; busy_seen = 0; bad_hot = 0; finished = 0;
    t[0] = '0; t[1] = '0; t[2] = '0;
    @(negedge clk);
    drive_cfg(v.delay, v.width, v.gap, v.num, v.mask);
    start = 1'b1;
    ack   = v.hold_ack;
    for (int k = 1; k <= 200 && !finished; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        // scramble config: the running campaign must not see it
        drive_cfg(v.delay + 16'd5, v.width + 16'd3, v.gap + 16'd2, v.num + 16'd5, ~v.mask);
      end
      fe = force_error;
      if ($countones(fe) > 1) bad_hot = 1;
      if (fe != '0 && prev == '0) begin
        if (npulse < 3) t[npulse] = fe;
        npulse++;
        if (npulse == 1) first = k;
        if (npulse == 2) second = k;
      end
      if (npulse == 1 && fe != '0) w1++;
      if (busy) busy_seen = 1;
      if (done) begin done_n++; done_k = k; end
      if (done_n > 0) begin post++; if (post > 3) finished = 1; end
      ack = v.hold_ack ? 1'b1 : (fe == '0 && prev != '0);
      prev = fe;
    end
    ack = 1'b0;
    check($sformatf("v%0d npulse", id), 32'(npulse), 32'(v.npulse));
    check($sformatf("v%0d inj_cnt", id), 32'(inj_cnt), 32'(v.cnt));
    check($sformatf("v%0d done_count", id), 32'(done_n), 32'd1);
    check($sformatf("v%0d done_cycle", id), 32'(done_k), 32'(v.done_k));
    check($sformatf("v%0d busy_seen", id), 32'(busy_seen), 32'(v.busy_seen));
    check($sformatf("v%0d busy_end", id), 32'(busy), 32'd0);
    check($sformatf("v%0d onehot_violation", id), 32'(bad_hot), 32'd0);
    if (v.npulse >= 1) begin
      check($sformatf("v%0d first_cycle", id), 32'(first), 32'(v.first));
      check($sformatf("v%0d first_width", id), 32'(w1), 32'(v.w));
      check($sformatf("v%0d tgt0", id), 32'(t[0]), 32'(v.t0));
    end
    if (v.npulse >= 2) begin
      check($sformatf("v%0d second_cycle", id), 32'(second), 32'(v.second));
      check($sformatf("v%0d tgt1", id), 32'(t[1]), 32'(v.t1));
    end
    if (v.npulse >= 3)
      check($sformatf("v%0d tgt2", id), 32'(t[2]), 32'(v.t2));
  endtask

  int done_seen;
  int busy_low;
  int done_k;

  initial begin
    //          delay  width  gap    num    mask    hold first sec w  t0      t1      t2      np cnt dk busy
    vecs[0] = '{16'd3, 16'd2, 16'd1, 16'd2, 3'b101, 1'b0, 4, 8, 2, 3'b001, 3'b100, 3'b000, 2, 2, 11, 1'b1};
    vecs[1] = '{16'd0, 16'd1, 16'd0, 16'd0, 3'b111, 1'b0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 1'b0};
    vecs[2] = '{16'd2, 16'd1, 16'd0, 16'd2, 3'b000, 1'b0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 1, 1'b0};
    vecs[3] = '{16'd0, 16'd0, 16'd0, 16'd4, 3'b010, 1'b0, 1, 3, 1, 3'b010, 3'b010, 3'b010, 4, 4, 9, 1'b1};
    vecs[4] = '{16'd0, 16'd2, 16'd0, 16'd3, 3'b111, 1'b1, 1, 4, 2, 3'b001, 3'b010, 3'b100, 3, 3, 10, 1'b1};
    vecs[5] = '{16'd1, 16'd1, 16'd2, 16'd2, 3'b110, 1'b1, 2, 6, 1, 3'b010, 3'b100, 3'b000, 2, 2, 8, 1'b1};
    vecs[6] = '{16'd0, 16'd1, 16'd0, 16'd3, 3'b101, 1'b0, 1, 3, 1, 3'b001, 3'b100, 3'b001, 3, 3, 7, 1'b1};

    rst = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    drive_cfg('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset force", 32'(force_error), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset inj_cnt", 32'(inj_cnt), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Abort in the middle of the second pulse
    @(negedge clk);
    drive_cfg(16'd0, 16'd3, 16'd0, 16'd3, 3'b011);
    start = 1'b1;
    @(negedge clk); start = 1'b0;       // cycle 1
    @(negedge clk); @(negedge clk);     // cycle 3
    @(negedge clk); ack = 1'b1;         // cycle 4, WAIT_ACK
    @(negedge clk); ack = 1'b0;         // cycle 5
    check("abort pre force", 32'(force_error), 32'b010);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;       // cycle 6
    check("abort force", 32'(force_error), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort inj_cnt", 32'(inj_cnt), 32'd1);
    done_seen = 0;
    repeat (4) begin @(negedge clk); if (done) done_seen++; end
    check("abort no_done", 32'(done_seen), 32'd0);

    // Abort beats start in IDLE: no campaign, counters untouched
    drive_cfg(16'd0, 16'd1, 16'd0, 16'd0, 3'b001);
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("abort_start busy", 32'(busy), 32'd0);
    check("abort_start done", 32'(done), 32'd0);
    check("abort_start inj_cnt", 32'(inj_cnt), 32'd1);

    // Synchronous reset during a pulse
    drive_cfg(16'd0, 16'd5, 16'd0, 16'd1, 3'b100);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("prerst force", 32'(force_error), 32'b100);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst force", 32'(force_error), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("midrst stays idle", 32'(busy), 32'd0);

    // No acknowledgement at all
    drive_cfg(16'd0, 16'd1, 16'd0, 16'd1, 3'b001);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("noack pulse", 32'(force_error), 32'b001);
`ifdef CB_HEEP_INJ_TIMEOUT_EN
    done_k = 0;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      if (done && done_k == 0) done_k = k;
    end
    check("timeout done_cycle", 32'(done_k), 32'd10);
    check("timeout flag", 32'(timeout), 32'd1);
    check("timeout inj_cnt", 32'(inj_cnt), 32'd0);
    check("timeout busy", 32'(busy), 32'd0);
    drive_cfg(16'd0, 16'd1, 16'd0, 16'd0, 3'b001);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("timeout cleared", 32'(timeout), 32'd0);
`else
    busy_low = 0; done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (done) done_seen++;
    end
    check("noack busy_held", 32'(busy_low), 32'd0);
    check("noack no_done", 32'(done_seen), 32'd0);
    check("noack timeout", 32'(timeout), 32'd0);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("noack abort busy", 32'(busy), 32'd0);
    check("noack inj_cnt", 32'(inj_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
